// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch and data access.
// Optional watchdog is enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  state_t              state, state_next;
  logic                last_data, last_data_next;   // 1: previous grant went to data
  logic                resp_data, resp_data_next;   // RESP cycle belongs to a data access
  logic                ihit_next, dhit_next;
  logic                ram_ren_next, ram_wen_next;
  logic [ADDR_W-1:0]   ramaddr_next;
  logic [DATA_W-1:0]   ramstore_next, iload_next, dload_next;
  logic                d_req, i_req, grant_d, timed_out;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  // A requester still holding its line during its own hit cycle is not a new request.
  assign d_req = (dREN | dWEN) & ~dhit;
  assign i_req = iREN & ~ihit;

  always_comb begin
    state_next     = state;
    last_data_next = last_data;
    resp_data_next = resp_data;
    ihit_next      = 1'b0;
    dhit_next      = 1'b0;
    ram_ren_next   = ramREN;
    ram_wen_next   = ramWEN;
    ramaddr_next   = ramaddr;
    ramstore_next  = ramstore;
    iload_next     = iload;
    dload_next     = dload;
    grant_d        = d_req & (~i_req | ~last_data);
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next    = DACC;
          ramaddr_next  = {daddr[ADDR_W-1:2], 2'b00};
          ramstore_next = dstore;
          ram_wen_next  = dWEN;
          ram_ren_next  = ~dWEN;
        end else if (i_req) begin
          state_next   = IACC;
          ramaddr_next = {iaddr[ADDR_W-1:2], 2'b00};
          ram_ren_next = 1'b1;
          ram_wen_next = 1'b0;
        end
      end
      DACC: begin
        if (ramready || timed_out) begin
          if (ramready && ramREN) dload_next = ramload;
          ram_ren_next   = 1'b0;
          ram_wen_next   = 1'b0;
          last_data_next = 1'b1;
          resp_data_next = 1'b1;
          state_next     = RESP;
        end
      end
      IACC: begin
        if (ramready || timed_out) begin
          if (ramready) iload_next = ramload;
          ram_ren_next   = 1'b0;
          ram_wen_next   = 1'b0;
          last_data_next = 1'b0;
          resp_data_next = 1'b0;
          state_next     = RESP;
        end
      end
      default: begin
        if (resp_data) dhit_next = dREN | dWEN;
        else           ihit_next = iREN;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      last_data <= 1'b0;
      resp_data <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      ramaddr   <= '0;
      ramstore  <= '0;
      iload     <= '0;
      dload     <= '0;
    end else begin
      state     <= state_next;
      last_data <= last_data_next;
      resp_data <= resp_data_next;
      ihit      <= ihit_next;
      dhit      <= dhit_next;
      ramREN    <= ram_ren_next;
      ramWEN    <= ram_wen_next;
      ramaddr   <= ramaddr_next;
      ramstore  <= ramstore_next;
      iload     <= iload_next;
      dload     <= dload_next;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          waiting;

  assign waiting   = ((state == DACC) || (state == IACC)) && !ramready;
  assign timed_out = waiting && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timed_out) timeout_err <= 1'b1;
      if (waiting && !timed_out) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single accesses, contention, withdrawal, reset abort, watchdog.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, timeout_err;
  int          n_vec = 0;
  int          n_bad = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    // reset state
    #12;
    chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
    chk("rst_ihit", ihit, 0); chk("rst_dhit", dhit, 0);
    chk("rst_iload", iload, 0); chk("rst_dload", dload, 0);
    chk("rst_terr", timeout_err, 0);
    nRST = 1'b1;
    tick();

    // instruction read, ramready two cycles after ramREN
    iREN = 1'b1; iaddr = 32'h100;
    tick();
    chk("i_ramREN", ramREN, 1); chk("i_ramWEN", ramWEN, 0); chk("i_ramaddr", ramaddr, 32'h100);
    tick(); tick();
    chk("i_hold_ramREN", ramREN, 1); chk("i_hold_ramaddr", ramaddr, 32'h100);
    ramready = 1'b1; ramload = 32'hDEADBEEF;
    tick();
    ramready = 1'b0;
    chk("i_cmd_drop", ramREN, 0); chk("i_early_hit", ihit, 0); chk("i_iload", iload, 32'hDEADBEEF);
    tick();
    chk("i_ihit", ihit, 1); chk("i_no_dhit", dhit, 0);
    iREN = 1'b0;
    tick();
    chk("i_ihit_pulse", ihit, 0);

    // data write, ramready immediately, unaligned address
    dWEN = 1'b1; daddr = 32'h203; dstore = 32'h12345678; ramready = 1'b1; ramload = 32'h0BADF00D;
    tick();
    chk("w_ramWEN", ramWEN, 1); chk("w_ramREN", ramREN, 0);
    chk("w_ramaddr", ramaddr, 32'h200); chk("w_ramstore", ramstore, 32'h12345678);
    tick();
    ramready = 1'b0;
    chk("w_cmd_drop", ramWEN, 0); chk("w_early_dhit", dhit, 0);
    tick();
    chk("w_dhit", dhit, 1); chk("w_dload_keep", dload, 0); chk("w_no_ihit", ihit, 0);
    dWEN = 1'b0;
    tick();
    chk("w_dhit_pulse", dhit, 0);

    // contention from reset: D, I, D, I
    nRST = 1'b0; #2; nRST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h400; daddr = 32'h800; ramready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ramload = 32'hCAFE0000 + k;
      tick();
      chk("rr_ramREN", ramREN, 1);
      chk("rr_ramaddr", ramaddr, (k % 2 == 0) ? 32'h800 : 32'h400);
      tick(); tick();
      chk("rr_dhit", dhit, (k % 2 == 0) ? 1 : 0);
      chk("rr_ihit", ihit, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) chk("rr_dload", dload, 32'hCAFE0000 + k);
      else            chk("rr_iload", iload, 32'hCAFE0000 + k);
    end
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
    tick();

    // data read withdrawn mid-access: load updated, hit suppressed
    dREN = 1'b1; daddr = 32'h30;
    tick();
    chk("wd_ramREN", ramREN, 1); chk("wd_ramaddr", ramaddr, 32'h30);
    dREN = 1'b0;
    tick();
    ramready = 1'b1; ramload = 32'h55AA55AA;
    tick();
    ramready = 1'b0;
    chk("wd_dload", dload, 32'h55AA55AA);
    tick();
    chk("wd_no_dhit", dhit, 0); chk("wd_no_ihit", ihit, 0);
    tick();

    // asynchronous reset during an instruction access
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    chk("ar_ramREN", ramREN, 1);
    #2; nRST = 1'b0; #1;
    chk("ar_ramREN_drop", ramREN, 0); chk("ar_ramaddr", ramaddr, 0); chk("ar_ihit", ihit, 0);
    #3; nRST = 1'b1;
    tick();
    chk("ar_restart_ramREN", ramREN, 1); chk("ar_restart_ihit", ihit, 0);
    ramready = 1'b1; ramload = 32'h11223344;
    tick();
    ramready = 1'b0;
    tick();
    chk("ar_ihit", ihit, 1); chk("ar_iload", iload, 32'h11223344);
    iREN = 1'b0;
    tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
    // watchdog: ramready never returns
    nRST = 1'b0; #2; nRST = 1'b1;
    iREN = 1'b1; iaddr = 32'h80;
    tick();
    chk("to_ramREN", ramREN, 1);
    for (int k = 0; k < 7; k++) tick();
    chk("to_err_early", timeout_err, 0);
    tick();
    chk("to_err", timeout_err, 1); chk("to_cmd_drop", ramREN, 0);
    tick();
    chk("to_ihit", ihit, 1); chk("to_iload_keep", iload, 0);
    iREN = 1'b0;
    tick(); tick();
    chk("to_err_sticky", timeout_err, 1);
`else
    // without the watchdog the access waits indefinitely
    iREN = 1'b1; iaddr = 32'h80;
    tick();
    for (int k = 0; k < 20; k++) tick();
    chk("nt_ramREN_held", ramREN, 1); chk("nt_no_ihit", ihit, 0); chk("nt_terr", timeout_err, 0);
    nRST = 1'b0; iREN = 1'b0; #2; nRST = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single RAM port between instruction fetch and data memory access.
- Produces the ihit/dhit strobes that the pipeline hazard control uses to decide stalls and enables.
- Sits between the fetch/memory stages (upstream requesters) and the RAM model/controller (downstream).
- Serialises accesses, holds the RAM command stable until RAM signals completion, then returns the data with a one-cycle hit pulse.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active-low
- iREN  in  1  instruction read request, held high until ihit
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data
- ihit  out  1  instruction access complete, 1-cycle pulse
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data to write
- dload  out  DATA_W  data read data
- dhit  out  1  data access complete, 1-cycle pulse
- ramREN  out  1  RAM read command
- ramWEN  out  1  RAM write command
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ramready=1
- ramready  in  1  RAM access complete this cycle
- timeout_err  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset values:
  - state=IDLE; all outputs 0 (ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err).
  - last_grant=INSTR, so data is served first after reset.
- All outputs are registered.
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Data request (dREN|dWEN) only: go to DACC.
  - iREN only: go to IACC.
  - Both pending: grant the opposite of last_grant (round-robin, prevents instruction starvation).
  - On the transition edge, latch address and store data into the ram* registers and assert ramREN or ramWEN.
  - dREN and dWEN both high: treated as a write (ramWEN=1, ramREN=0).
- DACC/IACC:
  - Hold the ram* outputs constant while ramready=0.
  - When ramready=1: capture ramload into dload (data read) or iload (instruction); dload is unchanged on a write.
  - On that same cycle: deassert ramREN/ramWEN, update last_grant, go to RESP.
- RESP:
  - Pulse dhit or ihit for exactly one cycle, then return to IDLE.
  - The hit is suppressed if the originating request line is low in the RESP cycle (requester withdrew, e.g. flush). Load data is still updated.
- Load outputs hold their last value until the next completion of the same type.
- Latency: request high at edge N gives ram command at N+1. ramready at edge M gives the hit pulse at M+1. Minimum of 3 cycles from request to hit when ramready returns in the first access cycle.
- Only one RAM command is outstanding at a time; ihit and dhit are never high together.
- ramaddr[1:0] is forced to 2'b00 (word aligned). Requester address bits [1:0] are ignored.
- Reset mid-access: the FSM aborts to IDLE immediately, ram commands drop, and no hit is produced.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to DACC/IACC and increments each cycle with ramready=0.
  - On reaching TIMEOUT: set timeout_err (sticky until reset), force RESP with no load update, emit the hit so the pipeline does not deadlock.
- When undefined: no counter exists, timeout_err is tied 0, and the FSM waits on ramready indefinitely.

Test Plan:
- iREN=1, iaddr=0x100, ramready high 2 cycles after ramREN, ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x100; ihit pulses 1 cycle; iload=0xDEADBEEF; dhit stays 0.
- dWEN=1, daddr=0x203, dstore=0x12345678, ramready immediate -> ramWEN=1, ramaddr=0x200, ramstore=0x12345678; dhit 3 cycles after request; dload unchanged.
- iREN and dREN high together from reset -> data served first, then instruction. Repeated contention alternates D, I, D, I; no two consecutive grants of the same type while both are pending.
- dREN drops during DACC before ramready -> access completes, dhit stays 0, dload still updated with ramload.
- nRST pulsed low while in IACC with ramREN=1 -> ramREN=0 asynchronously, no ihit; the next request starts from IDLE.
- MEM_ARBITER_TIMEOUT_EN defined, TIMEOUT=8, ramready held 0 -> timeout_err=1 after 8 wait cycles, hit pulse emitted, timeout_err stays 1 until reset.
